// File: rtl/mem_fairness_pkg.sv
// Shared types and payload layout for the memory-bus / sleep fairness monitor.
// Used by mem_fairness_monitor, fairness_counter and the benches.
package mem_fairness_pkg;

   localparam int unsigned ADDR_W    = 64;
   localparam int unsigned WEN_W     = 1;
   localparam int unsigned STRB_W    = 8;
   localparam int unsigned DATA_W    = 64;

   localparam int unsigned ADDR_LSB  = 0;
   localparam int unsigned WEN_LSB   = ADDR_LSB + ADDR_W;
   localparam int unsigned STRB_LSB  = WEN_LSB + WEN_W;
   localparam int unsigned DATA_LSB  = STRB_LSB + STRB_W;
   localparam int unsigned PAYLOAD_W = DATA_LSB + DATA_W;

   localparam int unsigned CW_DEF    = 5;

   typedef enum logic [1:0] {
      STALL,
      STABLE,
      RESP,
      SLEEP
   } viol_kind_e;

   function automatic logic [PAYLOAD_W-1:0] pack_payload(
      input logic [ADDR_W-1:0] addr,
      input logic [WEN_W-1:0]  wen,
      input logic [STRB_W-1:0] strb,
      input logic [DATA_W-1:0] data
   );
      logic [PAYLOAD_W-1:0] p;
      p = '0;
      p[ADDR_LSB +: ADDR_W] = addr;
      p[WEN_LSB  +: WEN_W]  = wen;
      p[STRB_LSB +: STRB_W] = strb;
      p[DATA_LSB +: DATA_W] = data;
      return p;
   endfunction

endpackage

// File: rtl/mem_fairness_monitor_counter.sv
// Saturating counter with a sticky, registered at-threshold flag.
// With MEM_FAIRNESS_ASSUME_EN defined, reaching the threshold is assumed away.
module fairness_counter
   import mem_fairness_pkg::*;
#(
   parameter int unsigned CW  = CW_DEF,
   parameter int unsigned THR = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc_i,
   input  logic          clr_i,
   input  logic          flag_clr_i,
   output logic [CW-1:0] cnt_o,
   output logic          at_thr_o
);

   localparam logic [CW-1:0] THR_C = CW'(THR);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          flag_q, flag_d;
   logic          hit;

   always_comb begin
      // NOTE: every comb output gets a default first, so no path can infer a latch.
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CW'(1);
      end
      hit    = (cnt_d >= THR_C);
      // A new hit outranks the flag clear arriving in the same cycle.
      flag_d = (flag_q & ~flag_clr_i) | hit;
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         flag_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
      end
   end

   assign cnt_o    = cnt_q;
   assign at_thr_o = flag_q;

`ifdef MEM_FAIRNESS_ASSUME_EN
   always_comb begin
      if (rst_n) begin
         assume (!hit);
      end
   end
`endif

endmodule

// File: rtl/mem_fairness_monitor.sv
// Per-channel stall / stability / response checks plus WFI sleep watchdog.
// Define MEM_FAIRNESS_ASSUME_EN to turn every violation condition into an assume.
module mem_fairness_monitor
   import mem_fairness_pkg::*;
#(
   parameter int unsigned NCH       = 2,
   parameter int unsigned PW        = PAYLOAD_W,
   parameter int unsigned CW        = CW_DEF,
   parameter int unsigned MAX_STALL = 5,
   parameter int unsigned MAX_SLEEP = 10
) (
   input  logic              g_clk,
   input  logic              g_resetn,
   input  logic [NCH-1:0]    ch_req,
   input  logic [NCH-1:0]    ch_gnt,
   input  logic [NCH-1:0]    ch_err,
   input  logic [NCH*PW-1:0] ch_payload,
   input  logic              wfi_sleep,
   input  logic              clear,
   output logic [NCH*CW-1:0] stall_cnt,
   output logic [CW-1:0]     sleep_cnt,
   output logic [NCH-1:0]    viol_stall,
   output logic [NCH-1:0]    viol_stable,
   output logic [NCH-1:0]    viol_resp,
   output logic              viol_sleep,
   output logic              viol_any
);

   logic [NCH-1:0]         stall_inc;
   logic [NCH-1:0]         pend_q, pend_d;
   logic [NCH-1:0]         gnt_q, gnt_d;
   logic [NCH-1:0]         stable_set, resp_set;
   logic [NCH-1:0]         stable_q, stable_d;
   logic [NCH-1:0]         resp_q, resp_d;
   logic [NCH-1:0][PW-1:0] pl_q, pl_d;

   always_comb begin
      stall_inc  = '0;
      pend_d     = '0;
      gnt_d      = '0;
      stable_set = '0;
      resp_set   = '0;
      pl_d       = pl_q;
      for (int i = 0; i < NCH; i++) begin
         stall_inc[i]  = ch_req[i] & ~ch_gnt[i];
         pend_d[i]     = stall_inc[i];
         gnt_d[i]      = ch_req[i] & ch_gnt[i];
         if (stall_inc[i]) begin
            pl_d[i] = ch_payload[i*PW +: PW];
         end
         stable_set[i] = pend_q[i] & (~ch_req[i] | (ch_payload[i*PW +: PW] != pl_q[i]));
         resp_set[i]   = ch_err[i] & ~gnt_q[i];
      end
      stable_d = (stable_q & {NCH{~clear}}) | stable_set;
      resp_d   = (resp_q   & {NCH{~clear}}) | resp_set;
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         pend_q   <= '0;
         gnt_q    <= '0;
         stable_q <= '0;
         resp_q   <= '0;
         // NOTE: the payload store is reset as well, so no state is X out of reset even though pend_q gates its use.
         pl_q     <= '0;
      end else begin
         pend_q   <= pend_d;
         gnt_q    <= gnt_d;
         stable_q <= stable_d;
         resp_q   <= resp_d;
         pl_q     <= pl_d;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_stall
      fairness_counter #(
         .CW  (CW),
         .THR (MAX_STALL)
      ) u_stall_ctr (
         .clk        (g_clk),
         .rst_n      (g_resetn),
         .inc_i      (stall_inc[i]),
         .clr_i      (~stall_inc[i]),
         .flag_clr_i (clear),
         .cnt_o      (stall_cnt[i*CW +: CW]),
         .at_thr_o   (viol_stall[i])
      );
   end

   fairness_counter #(
      .CW  (CW),
      .THR (MAX_SLEEP)
   ) u_sleep_ctr (
      .clk        (g_clk),
      .rst_n      (g_resetn),
      .inc_i      (wfi_sleep),
      .clr_i      (~wfi_sleep),
      .flag_clr_i (clear),
      .cnt_o      (sleep_cnt),
      .at_thr_o   (viol_sleep)
   );

   assign viol_stable = stable_q;
   assign viol_resp   = resp_q;
   assign viol_any    = (|viol_stall) | (|stable_q) | (|resp_q) | viol_sleep;

`ifdef MEM_FAIRNESS_ASSUME_EN
   initial assume (!g_resetn);

   always_comb begin
      if (g_resetn) begin
         assume (stable_set == '0);
         assume (resp_set == '0);
      end
   end
`endif

endmodule

// File: tb/tb_mem_fairness_monitor.sv
// Directed bench for mem_fairness_monitor with hand-computed expectations.
module tb_mem_fairness_monitor;
   import mem_fairness_pkg::*;

   localparam int unsigned NCH = 2;
   localparam int unsigned PW  = PAYLOAD_W;
   localparam int unsigned CW  = 5;

   logic              g_clk = 1'b0;
   logic              g_resetn;
   logic [NCH-1:0]    ch_req, ch_gnt, ch_err;
   logic [NCH*PW-1:0] ch_payload;
   logic              wfi_sleep, clear;
   logic [NCH*CW-1:0] stall_cnt;
   logic [CW-1:0]     sleep_cnt;
   logic [NCH-1:0]    viol_stall, viol_stable, viol_resp;
   logic              viol_sleep, viol_any;

   // {any, sleep, resp[1:0], stable[1:0], stall[1:0]}
   logic [7:0] flags;
   assign flags = {viol_any, viol_sleep, viol_resp, viol_stable, viol_stall};

   int pass_cnt = 0;
   int tot_cnt  = 0;

   mem_fairness_monitor #(
      .NCH       (NCH),
      .PW        (PW),
      .CW        (CW),
      .MAX_STALL (5),
      .MAX_SLEEP (10)
   ) dut (
      .g_clk       (g_clk),
      .g_resetn    (g_resetn),
      .ch_req      (ch_req),
      .ch_gnt      (ch_gnt),
      .ch_err      (ch_err),
      .ch_payload  (ch_payload),
      .wfi_sleep   (wfi_sleep),
      .clear       (clear),
      .stall_cnt   (stall_cnt),
      .sleep_cnt   (sleep_cnt),
      .viol_stall  (viol_stall),
      .viol_stable (viol_stable),
      .viol_resp   (viol_resp),
      .viol_sleep  (viol_sleep),
      .viol_any    (viol_any)
   );

   always #5 g_clk = ~g_clk;

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge g_clk);
         #1;
      end
   endtask

   function automatic logic [PW-1:0] mk(input logic [63:0] addr);
      return pack_payload(addr, 1'b1, 8'hff, 64'hdead_beef_0000_0000 | addr);
   endfunction

   task automatic test_reset();
      g_resetn   = 1'b0;
      ch_req     = '0;
      ch_gnt     = '0;
      ch_err     = '0;
      ch_payload = '0;
      wfi_sleep  = 1'b0;
      clear      = 1'b0;
      step(2);
      tot_cnt++;
      if ({stall_cnt, sleep_cnt, flags} !== '0)
         $display("FAIL reset_outputs: got %0h expected 0", {stall_cnt, sleep_cnt, flags});
      else pass_cnt++;
      g_resetn = 1'b1;
      step(1);
      tot_cnt++;
      if ({stall_cnt, sleep_cnt, flags} !== '0)
         $display("FAIL post_reset_idle: got %0h expected 0", {stall_cnt, sleep_cnt, flags});
      else pass_cnt++;
   endtask

   task automatic test_stall();
      ch_payload[0*PW +: PW] = mk(64'h40);
      ch_req[0] = 1'b1;
      step(4);
      tot_cnt++;
      if (stall_cnt[CW-1:0] !== 5'd4) $display("FAIL stall4_cnt: got %0d expected 4", stall_cnt[CW-1:0]);
      else pass_cnt++;
      tot_cnt++;
      if (flags !== 8'h00) $display("FAIL stall4_flags: got %0h expected 00", flags);
      else pass_cnt++;
      ch_gnt[0] = 1'b1;
      step(1);
      tot_cnt++;
      if ({stall_cnt[CW-1:0], flags} !== 13'd0)
         $display("FAIL stall4_grant: cnt %0d flags %0h expected 0/00", stall_cnt[CW-1:0], flags);
      else pass_cnt++;
      ch_req[0] = 1'b0;
      ch_gnt[0] = 1'b0;
      step(1);
      ch_req[0] = 1'b1;
      step(4);
      tot_cnt++;
      if (flags !== 8'h00) $display("FAIL stall5_pre: got %0h expected 00", flags);
      else pass_cnt++;
      step(1);
      tot_cnt++;
      if (stall_cnt[CW-1:0] !== 5'd5) $display("FAIL stall5_cnt: got %0d expected 5", stall_cnt[CW-1:0]);
      else pass_cnt++;
      tot_cnt++;
      if (flags !== 8'h81) $display("FAIL stall5_flag: got %0h expected 81", flags);
      else pass_cnt++;
      step(30);
      tot_cnt++;
      if (stall_cnt[CW-1:0] !== 5'd31) $display("FAIL stall_saturate: got %0d expected 31", stall_cnt[CW-1:0]);
      else pass_cnt++;
      ch_gnt[0] = 1'b1;
      step(1);
      tot_cnt++;
      if ({stall_cnt[CW-1:0], flags} !== {5'd0, 8'h81})
         $display("FAIL stall_sticky: cnt %0d flags %0h expected 0/81", stall_cnt[CW-1:0], flags);
      else pass_cnt++;
      ch_req[0] = 1'b0;
      ch_gnt[0] = 1'b0;
      clear     = 1'b1;
      step(1);
      clear = 1'b0;
      tot_cnt++;
      if (flags !== 8'h00) $display("FAIL stall_clear: got %0h expected 00", flags);
      else pass_cnt++;
   endtask

   task automatic test_stable();
      ch_payload[1*PW +: PW] = mk(64'h1000);
      ch_req[1] = 1'b1;
      step(2);
      tot_cnt++;
      if (flags !== 8'h00) $display("FAIL stable_hold: got %0h expected 00", flags);
      else pass_cnt++;
      ch_payload[1*PW +: PW] = mk(64'h1008);
      step(1);
      tot_cnt++;
      if (flags !== 8'h88) $display("FAIL stable_addr_change: got %0h expected 88", flags);
      else pass_cnt++;
      ch_gnt[1] = 1'b1;
      step(1);
      ch_req[1] = 1'b0;
      ch_gnt[1] = 1'b0;
      clear     = 1'b1;
      step(1);
      clear = 1'b0;
      tot_cnt++;
      if (flags !== 8'h00) $display("FAIL stable_clear1: got %0h expected 00", flags);
      else pass_cnt++;
      ch_req[1] = 1'b1;
      step(2);
      ch_req[1] = 1'b0;
      step(1);
      tot_cnt++;
      if (flags !== 8'h88) $display("FAIL stable_req_drop: got %0h expected 88", flags);
      else pass_cnt++;
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      tot_cnt++;
      if (flags !== 8'h00) $display("FAIL stable_clear2: got %0h expected 00", flags);
      else pass_cnt++;
   endtask

   task automatic test_resp();
      ch_req[0] = 1'b1;
      ch_gnt[0] = 1'b1;
      step(1);
      ch_req[0] = 1'b0;
      ch_gnt[0] = 1'b0;
      ch_err[0] = 1'b1;
      step(1);
      tot_cnt++;
      if (flags !== 8'h00) $display("FAIL resp_after_grant: got %0h expected 00", flags);
      else pass_cnt++;
      step(1);
      tot_cnt++;
      if (flags !== 8'h90) $display("FAIL resp_spurious: got %0h expected 90", flags);
      else pass_cnt++;
      ch_err[0] = 1'b0;
      clear     = 1'b1;
      step(1);
      clear = 1'b0;
   endtask

   task automatic test_sleep();
      wfi_sleep = 1'b1;
      step(9);
      tot_cnt++;
      if ({sleep_cnt, flags} !== {5'd9, 8'h00})
         $display("FAIL sleep9: cnt %0d flags %0h expected 9/00", sleep_cnt, flags);
      else pass_cnt++;
      wfi_sleep = 1'b0;
      step(1);
      tot_cnt++;
      if (sleep_cnt !== 5'd0) $display("FAIL sleep_wake: got %0d expected 0", sleep_cnt);
      else pass_cnt++;
      wfi_sleep = 1'b1;
      step(9);
      tot_cnt++;
      if (flags !== 8'h00) $display("FAIL sleep_pre10: got %0h expected 00", flags);
      else pass_cnt++;
      step(1);
      tot_cnt++;
      if ({sleep_cnt, flags} !== {5'd10, 8'hC0})
         $display("FAIL sleep10: cnt %0d flags %0h expected 10/c0", sleep_cnt, flags);
      else pass_cnt++;
      wfi_sleep = 1'b0;
      clear     = 1'b1;
      step(1);
      clear = 1'b0;
   endtask

   task automatic test_clear_race();
      ch_err[1] = 1'b1;
      step(1);
      tot_cnt++;
      if (flags !== 8'hA0) $display("FAIL race_setup: got %0h expected a0", flags);
      else pass_cnt++;
      ch_err[1] = 1'b0;
      ch_err[0] = 1'b1;
      clear     = 1'b1;
      step(1);
      tot_cnt++;
      if (flags !== 8'h90) $display("FAIL race_set_wins: got %0h expected 90", flags);
      else pass_cnt++;
      ch_err[0] = 1'b0;
      step(1);
      clear = 1'b0;
      tot_cnt++;
      if ({viol_any, flags} !== 9'h000) $display("FAIL race_clear_all: got %0h expected 000", {viol_any, flags});
      else pass_cnt++;
   endtask

   task automatic test_all_channels();
      ch_payload[0*PW +: PW] = mk(64'h2000);
      ch_payload[1*PW +: PW] = mk(64'h3000);
      ch_req = 2'b11;
      step(4);
      ch_err = 2'b11;
      step(1);
      ch_err = 2'b00;
      tot_cnt++;
      if ({stall_cnt, flags} !== {5'd5, 5'd5, 8'hB3})
         $display("FAIL all_ch: cnt %0h flags %0h expected a5/b3", stall_cnt, flags);
      else pass_cnt++;
      ch_gnt = 2'b11;
      step(1);
      ch_req = 2'b00;
      ch_gnt = 2'b00;
      clear  = 1'b1;
      step(1);
      clear = 1'b0;
      tot_cnt++;
      if ({stall_cnt, flags} !== '0) $display("FAIL all_ch_clear: got %0h expected 0", {stall_cnt, flags});
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_stall();
      ch_err[0] = 1'b1;
      step(1);
      ch_err[0] = 1'b0;
      ch_req[0] = 1'b1;
      step(3);
      tot_cnt++;
      if ({stall_cnt[CW-1:0], flags} !== {5'd3, 8'h90})
         $display("FAIL midrst_pre: cnt %0d flags %0h expected 3/90", stall_cnt[CW-1:0], flags);
      else pass_cnt++;
      #2;
      g_resetn = 1'b0;
      #1;
      tot_cnt++;
      if ({stall_cnt, sleep_cnt, flags} !== '0)
         $display("FAIL midrst_async: got %0h expected 0", {stall_cnt, sleep_cnt, flags});
      else pass_cnt++;
      ch_req[0] = 1'b0;
      step(1);
      g_resetn = 1'b1;
      ch_req[0] = 1'b1;
      step(1);
      tot_cnt++;
      if ({stall_cnt[CW-1:0], flags} !== {5'd1, 8'h00})
         $display("FAIL midrst_fresh: cnt %0d flags %0h expected 1/00", stall_cnt[CW-1:0], flags);
      else pass_cnt++;
      ch_gnt[0] = 1'b1;
      step(1);
      ch_req[0] = 1'b0;
      ch_gnt[0] = 1'b0;
      step(1);
   endtask

   initial begin
      test_reset();
      test_stall();
      test_stable();
      test_resp();
      test_sleep();
      test_clear_race();
      test_all_channels();
      test_reset_mid_stall();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: time %0t exceeded limit 50000", $time);
      $fatal(1);
   end

endmodule
